// File: rtl/decode_stage.sv
// MIPS decode stage: field split, R/I/J classification and immediate extension
// behind a two-entry (output + skid) buffer. Optional macro: DECODE_ILLEGAL_EN.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [XLEN-1:0]   out_imm,
  output logic [25:0]       out_jaddr,
  output logic [1:0]        out_itype,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  dec_count
);

  // state | meaning
  // EMPTY | nothing buffered, output register invalid
  // ONE   | output register holds the head entry
  // TWO   | output register and skid register both hold entries
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [1:0] ITYPE_R = 2'b00;
  localparam logic [1:0] ITYPE_I = 2'b01;
  localparam logic [1:0] ITYPE_J = 2'b10;

  typedef struct packed {
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [XLEN-1:0] imm;
    logic [25:0]     jaddr;
    logic [1:0]      itype;
    logic            illegal;
  } dec_t;

`ifdef DECODE_ILLEGAL_EN
  function automatic logic is_illegal(input logic [31:0] instr);
    logic bad;
    bad = 1'b0;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h00, 6'h02, 6'h03, 6'h08,
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: bad = 1'b0;
          default:      bad = 1'b1;
        endcase
      end
      6'h02, 6'h03, 6'h04, 6'h05,
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h23, 6'h2B: bad = 1'b0;
      default:      bad = 1'b1;
    endcase
    return bad;
  endfunction
`endif

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t        d;
    logic [31:0] lui_val;
    d        = '0;
    lui_val  = {instr[15:0], 16'b0};
    d.opcode = instr[31:26];
    case (instr[31:26])
      6'h00: begin
        d.rs    = instr[25:21];
        d.rt    = instr[20:16];
        d.rd    = instr[15:11];
        d.shamt = instr[10:6];
        d.funct = instr[5:0];
        d.itype = ITYPE_R;
      end
      6'h02, 6'h03: begin
        d.jaddr = instr[25:0];
        d.itype = ITYPE_J;
      end
      default: begin
        d.rs    = instr[25:21];
        d.rt    = instr[20:16];
        d.itype = ITYPE_I;
        // Fill the upper bits first, then overlay the low word; works for XLEN == 32.
        case (instr[31:26])
          6'h0C, 6'h0D, 6'h0E: begin
            d.imm       = '0;
            d.imm[15:0] = instr[15:0];
          end
          6'h0F: begin
            d.imm       = {XLEN{lui_val[31]}};
            d.imm[31:0] = lui_val;
          end
          default: begin
            d.imm       = {XLEN{instr[15]}};
            d.imm[15:0] = instr[15:0];
          end
        endcase
      end
    endcase
`ifdef DECODE_ILLEGAL_EN
    d.illegal = is_illegal(instr);
`else
    d.illegal = 1'b0;
`endif
    return d;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  dec_t             r_out;
  dec_t             r_skid;
  dec_t             w_dec;
  logic [CNT_W-1:0] r_count;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_load_out;
  logic             w_load_skid;
  logic             w_skid_to_out;

  assign w_dec      = decode(in_instr);
  assign in_ready   = (r_state != TWO);
  assign out_valid  = (r_state != EMPTY);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_load_out  = 1'b1;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_out = 1'b1;
        end else if (w_in_xfer) begin
          w_load_skid = 1'b1;
          w_state_nxt = TWO;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_out_xfer) begin
          w_skid_to_out = 1'b1;
          w_state_nxt   = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_skid  <= '0;
      r_count <= '0;
    end else begin
      if (w_load_out) begin
        r_out <= w_dec;
      end else if (w_skid_to_out) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
      if (w_out_xfer) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign out_opcode  = r_out.opcode;
  assign out_rs      = r_out.rs;
  assign out_rt      = r_out.rt;
  assign out_rd      = r_out.rd;
  assign out_shamt   = r_out.shamt;
  assign out_funct   = r_out.funct;
  assign out_imm     = r_out.imm;
  assign out_jaddr   = r_out.jaddr;
  assign out_itype   = r_out.itype;
  assign out_illegal = r_out.illegal;
  assign dec_count   = r_count;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit/32-bit-counter instance plus a
// 64-bit/2-bit-counter instance fed the same stream.
module tb_decode_stage;

`ifdef DECODE_ILLEGAL_EN
  localparam bit ILL_ON = 1'b1;
`else
  localparam bit ILL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [31:0] out_imm;
  logic [25:0] out_jaddr;
  logic [1:0]  out_itype;
  logic [31:0] dec_count;

  logic        w64_in_ready, w64_out_valid, w64_illegal;
  logic [5:0]  w64_opcode, w64_funct;
  logic [4:0]  w64_rs, w64_rt, w64_rd, w64_shamt;
  logic [63:0] w64_imm;
  logic [25:0] w64_jaddr;
  logic [1:0]  w64_itype;
  logic [1:0]  w64_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm(out_imm),
    .out_jaddr(out_jaddr), .out_itype(out_itype), .out_illegal(out_illegal),
    .dec_count(dec_count)
  );

  decode_stage #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w64_in_ready),
    .in_instr(in_instr), .out_valid(w64_out_valid), .out_ready(out_ready),
    .out_opcode(w64_opcode), .out_rs(w64_rs), .out_rt(w64_rt), .out_rd(w64_rd),
    .out_shamt(w64_shamt), .out_funct(w64_funct), .out_imm(w64_imm),
    .out_jaddr(w64_jaddr), .out_itype(w64_itype), .out_illegal(w64_illegal),
    .dec_count(w64_count)
  );

  // Present one instruction; returns at the negedge where its fields are visible.
  task automatic send_one(input logic [31:0] instr);
    @(negedge clk);
    in_valid  = 1'b1;
    in_instr  = instr;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  // Lets the pending output transfer complete.
  task automatic drain();
    @(negedge clk);
    exp_count++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (dec_count !== 32'd0) $display("FAIL reset_dec_count: got %0d expected 0", dec_count); else pass_cnt++;
    total_cnt++; if (out_imm !== 32'd0 || out_opcode !== 6'd0) $display("FAIL reset_fields: got imm %h op %h expected 0", out_imm, out_opcode); else pass_cnt++;
  endtask

  task automatic test_lw();
    send_one(32'h8E120000);
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL lw_valid: got %b expected 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_opcode !== 6'h23) $display("FAIL lw_opcode: got %h expected 23", out_opcode); else pass_cnt++;
    total_cnt++; if (out_rs !== 5'd16 || out_rt !== 5'd18 || out_rd !== 5'd0) $display("FAIL lw_regs: got rs %0d rt %0d rd %0d expected 16 18 0", out_rs, out_rt, out_rd); else pass_cnt++;
    total_cnt++; if (out_imm !== 32'h0 || out_itype !== 2'b01) $display("FAIL lw_imm_type: got imm %h type %b expected 0 01", out_imm, out_itype); else pass_cnt++;
    drain();
    total_cnt++; if (dec_count !== 32'd1) $display("FAIL lw_count: got %0d expected 1", dec_count); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL lw_empty: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_imm();
    send_one(32'h2009FFFF);
    total_cnt++; if (out_imm !== 32'hFFFFFFFF) $display("FAIL addi_imm32: got %h expected FFFFFFFF", out_imm); else pass_cnt++;
    total_cnt++; if (w64_imm !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL addi_imm64: got %h expected FFFFFFFFFFFFFFFF", w64_imm); else pass_cnt++;
    drain();
    send_one(32'h3409FFFF);
    total_cnt++; if (out_imm !== 32'h0000FFFF) $display("FAIL ori_imm32: got %h expected 0000FFFF", out_imm); else pass_cnt++;
    total_cnt++; if (w64_imm !== 64'h000000000000FFFF) $display("FAIL ori_imm64: got %h expected 000000000000FFFF", w64_imm); else pass_cnt++;
    drain();
    send_one(32'h3C081234);
    total_cnt++; if (out_imm !== 32'h12340000) $display("FAIL lui_imm32: got %h expected 12340000", out_imm); else pass_cnt++;
    total_cnt++; if (w64_imm !== 64'h0000000012340000) $display("FAIL lui_imm64: got %h expected 0000000012340000", w64_imm); else pass_cnt++;
    drain();
    send_one(32'h3C088000);
    total_cnt++; if (w64_imm !== 64'hFFFFFFFF80000000) $display("FAIL lui_neg_imm64: got %h expected FFFFFFFF80000000", w64_imm); else pass_cnt++;
    drain();
  endtask

  task automatic test_rtype_jtype();
    send_one(32'h012A4020);
    total_cnt++; if (out_rs !== 5'd9 || out_rt !== 5'd10 || out_rd !== 5'd8) $display("FAIL add_regs: got rs %0d rt %0d rd %0d expected 9 10 8", out_rs, out_rt, out_rd); else pass_cnt++;
    total_cnt++; if (out_funct !== 6'h20 || out_shamt !== 5'd0) $display("FAIL add_funct: got funct %h shamt %0d expected 20 0", out_funct, out_shamt); else pass_cnt++;
    total_cnt++; if (out_imm !== 32'h0 || out_itype !== 2'b00) $display("FAIL add_imm_type: got imm %h type %b expected 0 00", out_imm, out_itype); else pass_cnt++;
    drain();
    send_one(32'h0C100004);
    total_cnt++; if (out_jaddr !== 26'h0100004) $display("FAIL jal_jaddr: got %h expected 0100004", out_jaddr); else pass_cnt++;
    total_cnt++; if (out_itype !== 2'b10 || out_opcode !== 6'h03) $display("FAIL jal_type: got type %b op %h expected 10 03", out_itype, out_opcode); else pass_cnt++;
    total_cnt++; if (out_rs !== 5'd0 || out_rt !== 5'd0 || out_imm !== 32'h0) $display("FAIL jal_zero: got rs %0d rt %0d imm %h expected 0 0 0", out_rs, out_rt, out_imm); else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [6];
    logic [15:0] lo;
    logic [31:0] exp_imm;
    logic        exp_rdy;
    int tx, rx, c;
    for (int i = 0; i < 6; i++) begin
      lo = (i % 2 == 1) ? (16'h8000 + 16'(i)) : (16'h0100 + 16'(i));
      instrs[i] = {6'h08, 5'd3, 5'd9, lo};
    end
    tx = 0;
    rx = 0;
    for (c = 1; c <= 30 && rx < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 5);
      in_valid  = (tx < 6);
      if (tx < 6) in_instr = instrs[tx];
      if (c <= 11) begin
        exp_rdy = !(c >= 3 && c <= 6);
        total_cnt++; if (in_ready !== exp_rdy) $display("FAIL b2b_in_ready_c%0d: got %b expected %b", c, in_ready, exp_rdy); else pass_cnt++;
      end
      #1;
      if (out_valid === 1'b1) begin
        exp_imm = {{16{instrs[rx][15]}}, instrs[rx][15:0]};
        total_cnt++; if (out_imm !== exp_imm || out_rt !== 5'd9) $display("FAIL b2b_head_c%0d: got imm %h rt %0d expected %h 9", c, out_imm, out_rt, exp_imm); else pass_cnt++;
        if (out_ready) begin
          rx++;
          exp_count++;
        end
      end
      if (in_valid && in_ready) tx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    total_cnt++; if (rx !== 6 || tx !== 6) $display("FAIL b2b_total: got rx %0d tx %0d expected 6 6", rx, tx); else pass_cnt++;
    total_cnt++; if (dec_count !== 32'(exp_count)) $display("FAIL b2b_count: got %0d expected %0d", dec_count, exp_count); else pass_cnt++;
    total_cnt++; if (w64_count !== 2'(exp_count)) $display("FAIL b2b_count_wrap: got %0d expected %0d", w64_count, exp_count % 4); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h2009AAAA;
    @(negedge clk);
    in_instr  = 32'h20095555;
    @(negedge clk);
    in_valid  = 1'b0;
    total_cnt++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL mid_full: got in_ready %b out_valid %b expected 0 1", in_ready, out_valid); else pass_cnt++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL mid_flags: got out_valid %b in_ready %b expected 0 1", out_valid, in_ready); else pass_cnt++;
    total_cnt++; if (dec_count !== 32'd0 || out_imm !== 32'd0) $display("FAIL mid_clear: got count %0d imm %h expected 0 0", dec_count, out_imm); else pass_cnt++;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL mid_ghost_%0d: got out_valid %b expected 0", k, out_valid); else pass_cnt++;
    end
  endtask

  task automatic test_illegal();
    send_one(32'hFC000000);
    total_cnt++; if (out_illegal !== ILL_ON) $display("FAIL ill_opcode: got %b expected %b", out_illegal, ILL_ON); else pass_cnt++;
    total_cnt++; if (out_itype !== 2'b01 || out_opcode !== 6'h3F) $display("FAIL ill_opcode_fields: got type %b op %h expected 01 3F", out_itype, out_opcode); else pass_cnt++;
    drain();
    send_one(32'h00000001);
    total_cnt++; if (out_illegal !== ILL_ON) $display("FAIL ill_funct: got %b expected %b", out_illegal, ILL_ON); else pass_cnt++;
    total_cnt++; if (out_funct !== 6'h01 || out_itype !== 2'b00) $display("FAIL ill_funct_fields: got funct %h type %b expected 01 00", out_funct, out_itype); else pass_cnt++;
    drain();
    send_one(32'h8E120000);
    total_cnt++; if (out_illegal !== 1'b0) $display("FAIL ill_lw: got %b expected 0", out_illegal); else pass_cnt++;
    drain();
    total_cnt++; if (dec_count !== 32'(exp_count)) $display("FAIL ill_count: got %0d expected %0d", dec_count, exp_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_imm();
    test_rtype_jtype();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
